booth_multiplier_param: RTL and testbench
=========================================

BOOTH_MULTIPLIER_PARAM -- requirements
Module: booth_multiplier_param

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set operand width and data bus width; legal range 4..32.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new multiply; it is sampled only in IDLE.
REQ-005 signed_mode  input  1  SHALL select signed (1) or unsigned (0) operands; it is latched on the accepted start edge.
REQ-006 data_in  input  WIDTH  SHALL be the shared serial operand bus.
REQ-007 data_out  output  WIDTH  SHALL carry one product word while done=1, and zero otherwise.
REQ-008 done  output  1  SHALL be high during the two result cycles.
REQ-009 out_hi  output  1  SHALL be high while data_out holds the upper product word, and low otherwise.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-011 The state machine SHALL have the states IDLE, LOAD_A, LOAD_B, CALC, OUT_HI and OUT_LO.
REQ-012 IDLE with start=1 at edge T SHALL move to LOAD_A and latch signed_mode.
REQ-013 At edge T+1, data_in SHALL be captured as the multiplicand A, and the state SHALL move to LOAD_B.
REQ-014 At edge T+2, data_in SHALL be captured as the multiplier B, the accumulator and Booth bit SHALL clear, the iteration counter SHALL load K, and the state SHALL move to CALC.
REQ-015 K SHALL be WIDTH when signed_mode=1, and WIDTH+1 when signed_mode=0; in unsigned mode, A and B SHALL be zero-extended by one bit.
REQ-016 Each CALC cycle SHALL perform one radix-2 Booth step:
- pair {B lsb, Booth bit} = 01: add A;
- pair = 10: subtract A;
- then arithmetic-shift {acc, B, Booth bit} right by one bit;
- decrement the counter.
REQ-017 The accumulator SHALL be WIDTH+2 bits, so that a most-negative by most-negative product and unsigned maximum products are exact.
REQ-018 CALC SHALL last exactly K cycles and then move to OUT_HI.
REQ-019 Latency SHALL be: done rises after edge T+2+K; OUT_HI and OUT_LO each last one cycle; the state returns to IDLE after edge T+4+K.
REQ-020 OUT_HI SHALL drive product[2*WIDTH-1:WIDTH] with out_hi=1; OUT_LO SHALL drive product[WIDTH-1:0] with out_hi=0.
REQ-021 The product SHALL be the exact 2*WIDTH-bit result: two's complement in signed mode, and unsigned otherwise.
REQ-022 start SHALL be ignored in every state other than IDLE, including OUT_LO; a new start is accepted at the first IDLE edge.
REQ-023 start held high continuously SHALL cause back-to-back operations, each spaced by K+5 cycles.
REQ-024 data_in SHALL be ignored outside LOAD_A and LOAD_B.
REQ-025 Outputs SHALL be derived from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1 at an edge, the state SHALL become IDLE and all datapath registers SHALL clear, with priority over start.
REQ-027 After reset: data_out=0, done=0, out_hi=0, busy=0.
REQ-028 Reset asserted in any state, including mid-CALC or OUT_HI, SHALL abort the operation; no done pulse follows.

Verification
REQ-029 WIDTH=5, signed: start, then A=01101, then B=01010 -> after 7 cycles, done with out_hi=1, data_out=00100; next cycle out_hi=0, data_out=00010 (130).
REQ-030 WIDTH=5, signed products:
- 11101 x 01010 -> 11111 / 00010 (-30);
- 01101 x 11010 -> 11101 / 10010 (-78);
- 11101 x 11010 -> 00000 / 10010 (18);
- 00000 x 01010 -> 00000 / 00000.
REQ-031 WIDTH=5, unsigned: 11101 x 11010 -> done after 8 cycles; 10111 / 10010 (754).
REQ-032 WIDTH=8, signed: 0x80 x 0x80 -> 0x40 / 0x00; unsigned 0xFF x 0xFF -> 0xFE / 0x01.
REQ-033 rst pulsed mid-CALC -> the next cycle shows busy=0 and done=0; a subsequent start completes correctly.
REQ-034 A start pulse during CALC or OUT_LO SHALL be ignored; start held high SHALL give consecutive results spaced K+5 cycles apart.

Source files
------------

// File: rtl/booth_multiplier_param.sv
// Serial-load radix-2 Booth multiplier, signed or unsigned operands.
// One Booth step per cycle; product is read out as two words.
module booth_multiplier_param #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             out_hi,
  output logic             busy
);

  localparam int AW = WIDTH + 2;
  localparam int BW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    OUT_HI,
    OUT_LO
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [BW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [BW-1:0] ext_in;
  logic [AW-1:0] a_sx;
  logic [AW-1:0] sum;
  logic [PW-1:0] prod;

  // Operand widening: sign-extend when signed, zero-extend otherwise
  always_comb begin
    ext_in = {1'b0, data_in};
    if (mode_q) begin
      ext_in = {data_in[WIDTH-1], data_in};
    end
    a_sx = {a_q[BW-1], a_q};
  end

  // Booth add/subtract selected by the current bit pair
  always_comb begin
    sum = acc_q;
    case ({b_q[0], bit_q})
      2'b01:   sum = acc_q + a_sx;
      2'b10:   sum = acc_q - a_sx;
      default: sum = acc_q;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          mode_d  = signed_mode;
        end
      end
      LOAD_A: begin
        a_d     = ext_in;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = ext_in;
        acc_d   = '0;
        bit_d   = 1'b0;
        cnt_d   = mode_q ? CW'(WIDTH) : CW'(WIDTH + 1);
        state_d = CALC;
      end
      CALC: begin
        acc_d = {sum[AW-1], sum[AW-1:1]};
        b_d   = {sum[0], b_q[BW-1:1]};
        bit_d = b_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = OUT_HI;
        end
      end
      OUT_HI: begin
        state_d = OUT_LO;
      end
      OUT_LO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      bit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unsigned runs one extra step, so the product sits one bit lower
  always_comb begin
    prod = {acc_q[WIDTH-2:0], b_q};
    if (mode_q) begin
      prod = {acc_q[WIDTH-1:0], b_q[BW-1:1]};
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    data_out = '0;
    done     = 1'b0;
    out_hi   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      OUT_HI: begin
        data_out = prod[PW-1:WIDTH];
        done     = 1'b1;
        out_hi   = 1'b1;
      end
      OUT_LO: begin
        data_out = prod[WIDTH-1:0];
        done     = 1'b1;
      end
      default: begin
        data_out = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Bench for booth_multiplier_param at WIDTH=5 and WIDTH=8.
// Results are compared against plain integer multiplication.
module tb_booth_multiplier_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       start5, start8;
  logic       signed_mode;
  logic [7:0] din;
  logic [4:0] dout5;
  logic [7:0] dout8;
  logic       done5, done8, ohi5, ohi8, busy5, busy8;
  logic       sel8;
  logic [7:0] dout;
  logic       done, ohi, busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  booth_multiplier_param #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .start(start5),
    .signed_mode(signed_mode), .data_in(din[4:0]),
    .data_out(dout5), .done(done5), .out_hi(ohi5), .busy(busy5)
  );

  booth_multiplier_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .signed_mode(signed_mode), .data_in(din),
    .data_out(dout8), .done(done8), .out_hi(ohi8), .busy(busy8)
  );

  assign dout = sel8 ? dout8 : {3'b000, dout5};
  assign done = sel8 ? done8 : done5;
  assign ohi  = sel8 ? ohi8 : ohi5;
  assign busy = sel8 ? busy8 : busy5;

  function automatic logic [15:0] refp(input int w, input bit m,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    longint sa, sb, p, full;
    full = longint'(1) << w;
    sa = longint'(a) & (full - 1);
    sb = longint'(b) & (full - 1);
    if (m) begin
      if (sa >= full / 2) sa = sa - full;
      if (sb >= full / 2) sb = sb - full;
    end
    p = sa * sb;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return 16'(p);
  endfunction

  function automatic logic [7:0] hiw(input int w, input logic [15:0] p);
    return 8'((p >> w) & ((16'd1 << w) - 16'd1));
  endfunction

  function automatic logic [7:0] low(input int w, input logic [15:0] p);
    return 8'(p & ((16'd1 << w) - 16'd1));
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else start5 = v;
  endtask

  task automatic mul(input int w, input bit m,
                     input logic [7:0] a, input logic [7:0] b,
                     output int lat, output logic [7:0] hi,
                     output logic [7:0] lo, output logic ohi1,
                     output logic ohi2, output logic dn2,
                     output logic idle3);
    sel8 = (w == 8);
    @(negedge clk);
    signed_mode = m;
    set_start(w, 1'b1);
    din = 8'($urandom);
    @(negedge clk);
    set_start(w, 1'b0);
    signed_mode = 1'($urandom);
    din = a;
    @(negedge clk);
    din = b;
    @(negedge clk);
    din = 8'($urandom);
    lat = 2;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    hi = dout;
    ohi1 = ohi;
    @(negedge clk);
    lo = dout;
    ohi2 = ohi;
    dn2 = done;
    @(negedge clk);
    idle3 = !busy && !done && !ohi && (dout == 8'h00);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start5 = 1'b1;
    start8 = 1'b1;
    din = 8'hFF;
    signed_mode = 1'b1;
    repeat (3) @(negedge clk);
    start5 = 1'b0;
    start8 = 1'b0;
    rst = 1'b0;
    nvec++;
    if ({dout5, done5, ohi5, busy5} !== 8'h00) begin
      nerr++;
      $display("FAIL reset5 got %b want 0", {dout5, done5, ohi5, busy5});
    end
    nvec++;
    if ({dout8, done8, ohi8, busy8} !== 11'h000) begin
      nerr++;
      $display("FAIL reset8 got %b want 0", {dout8, done8, ohi8, busy8});
    end
  endtask

  task automatic test_directed;
    int          wv[10] = '{5, 5, 5, 5, 5, 5, 5, 5, 8, 8};
    bit          mv[10] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0};
    logic [7:0]  av[10] = '{8'h0D, 8'h1D, 8'h0D, 8'h1D, 8'h00,
                            8'h1D, 8'h10, 8'h1F, 8'h80, 8'hFF};
    logic [7:0]  bv[10] = '{8'h0A, 8'h0A, 8'h1A, 8'h1A, 8'h0A,
                            8'h1A, 8'h10, 8'h1F, 8'h80, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      int lat, k;
      logic [7:0] hi, lo;
      logic o1, o2, d2, id3;
      logic [15:0] p;
      mul(wv[i], mv[i], av[i], bv[i], lat, hi, lo, o1, o2, d2, id3);
      p = refp(wv[i], mv[i], av[i], bv[i]);
      k = mv[i] ? wv[i] : wv[i] + 1;
      nvec++;
      if (lat !== 2 + k) begin
        nerr++;
        $display("FAIL dir%0d latency got %0d want %0d", i, lat, 2 + k);
      end
      nvec++;
      if (hi !== hiw(wv[i], p)) begin
        nerr++;
        $display("FAIL dir%0d hi got %h want %h", i, hi, hiw(wv[i], p));
      end
      nvec++;
      if (lo !== low(wv[i], p)) begin
        nerr++;
        $display("FAIL dir%0d lo got %h want %h", i, lo, low(wv[i], p));
      end
      nvec++;
      if ({o1, o2, d2, id3} !== 4'b1011) begin
        nerr++;
        $display("FAIL dir%0d flags got %b want 1011", i,
                 {o1, o2, d2, id3});
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int w, lat, k;
      bit m;
      logic [7:0] a, b, hi, lo;
      logic o1, o2, d2, id3;
      logic [15:0] p;
      w = (i % 2 == 0) ? 5 : 8;
      m = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if (w == 5) begin
        a = a & 8'h1F;
        b = b & 8'h1F;
      end
      mul(w, m, a, b, lat, hi, lo, o1, o2, d2, id3);
      p = refp(w, m, a, b);
      k = m ? w : w + 1;
      nvec++;
      if (hi !== hiw(w, p) || lo !== low(w, p) || lat !== 2 + k) begin
        nerr++;
        $display("FAIL rnd w%0d m%0d %h*%h got %h/%h lat%0d want %h/%h lat%0d",
                 w, m, a, b, hi, lo, lat, hiw(w, p), low(w, p), 2 + k);
      end
    end
  endtask

  task automatic test_reset_mid_calc;
    bit seen;
    int lat;
    logic [7:0] hi, lo;
    logic o1, o2, d2, id3;
    sel8 = 1'b0;
    @(negedge clk);
    signed_mode = 1'b1;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    din = 8'h0D;
    @(negedge clk);
    din = 8'h0A;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if (busy5 !== 1'b0 || done5 !== 1'b0) begin
      nerr++;
      $display("FAIL rst_calc busy/done got %b%b want 00", busy5, done5);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done5 || busy5) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL rst_calc activity got %b want 0", seen);
    end
    mul(5, 1'b1, 8'h0D, 8'h0A, lat, hi, lo, o1, o2, d2, id3);
    nvec++;
    if ({hi, lo} !== {8'h04, 8'h02} || lat !== 7) begin
      nerr++;
      $display("FAIL rst_after got %h/%h lat%0d want 04/02 lat7",
               hi, lo, lat);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    logic [7:0] hi, lo;
    sel8 = 1'b0;
    @(negedge clk);
    signed_mode = 1'b1;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    din = 8'h1D;
    @(negedge clk);
    din = 8'h1A;
    repeat (3) @(negedge clk);
    start5 = 1'b1;
    signed_mode = 1'b0;
    din = 8'h15;
    @(negedge clk);
    start5 = 1'b0;
    n = 0;
    while (!done5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    hi = dout;
    @(negedge clk);
    lo = dout;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    nvec++;
    if ({hi, lo} !== {8'h00, 8'h12}) begin
      nerr++;
      $display("FAIL ign_calc got %h/%h want 00/12", hi, lo);
    end
    nvec++;
    if (busy5 !== 1'b0) begin
      nerr++;
      $display("FAIL ign_outlo busy got %b want 0", busy5);
    end
    @(negedge clk);
    nvec++;
    if (busy5 !== 1'b0) begin
      nerr++;
      $display("FAIL ign_idle busy got %b want 0", busy5);
    end
  endtask

  task automatic test_back_to_back;
    int cyc[2];
    logic [7:0] hv[2];
    logic [7:0] lv[2];
    int found = 0;
    bit prev = 1'b0;
    sel8 = 1'b0;
    @(negedge clk);
    signed_mode = 1'b1;
    din = 8'h07;
    start5 = 1'b1;
    for (int c = 0; c < 60 && found < 2; c++) begin
      @(negedge clk);
      if (done5 && !prev) begin
        cyc[found] = c;
        hv[found] = dout;
        @(negedge clk);
        lv[found] = dout;
        c++;
        found++;
      end
      prev = done5;
    end
    start5 = 1'b0;
    repeat (15) @(negedge clk);
    nvec++;
    if (found !== 2) begin
      nerr++;
      $display("FAIL b2b count got %0d want 2", found);
    end else begin
      nvec++;
      if (cyc[1] - cyc[0] !== 10) begin
        nerr++;
        $display("FAIL b2b spacing got %0d want 10", cyc[1] - cyc[0]);
      end
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if ({hv[i], lv[i]} !== {8'h01, 8'h11}) begin
          nerr++;
          $display("FAIL b2b%0d got %h/%h want 01/11", i, hv[i], lv[i]);
        end
      end
    end
  endtask

  initial begin
    sel8 = 1'b0;
    din = 8'h00;
    start5 = 1'b0;
    start8 = 1'b0;
    signed_mode = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_reset_mid_calc;
    test_ignore_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
